seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
Multi-cycle, width-parametrised ALU for the datapath; it generalises the current single-cycle ALU. Single-cycle ops produce a registered result one cycle after start. Multiply (radix-2 Booth) and divide (restoring, signed) run iteratively over WIDTH cycles behind a start/busy/done handshake. The result feeds the Z register as {HI, LO}: HI goes to mfhi and LO goes to mflo.

Parameters:
WIDTH, 32, operand width in bits; must be >= 4 and a power of two.
SHW, $clog2(WIDTH), shift/rotate amount width; the amount is taken from rb[SHW-1:0].

Ports:
clk  in  1  system clock; all logic rises on the posedge.
clear  in  1  synchronous active-high reset.
start  in  1  one-cycle request; sampled only while busy=0.
opcode  in  5  operation; encodings are listed in the shared package.
ra  in  WIDTH  operand A (dividend, multiplicand, shift source).
rb  in  WIDTH  operand B (divisor, multiplier, shift amount).
rc  out  2*WIDTH  result; HI = rc[2W-1:W], LO = rc[W-1:0].
busy  out  1  high while an iterative op is in flight.
done  out  1  one-cycle pulse when rc is updated.
div_by_zero  out  1  sticky until the next accepted start.

Behaviour:
- Reset (clear=1 at a posedge) sets rc=0, busy=0, done=0, div_by_zero=0 and state IDLE. Reset aborts any in-flight op and gives no done pulse.
- State machine: IDLE, MUL, DIV, FIN.
- IDLE with start=1 and a single-cycle opcode: compute, latch rc and pulse done in the next cycle. Latency is 1 and the machine stays in IDLE.
- IDLE with start=1 and opcode=mul: latch the operands, set busy, and go to MUL with count=WIDTH.
- IDLE with start=1 and opcode=div, rb!=0: latch the operands, set busy, and go to DIV with count=WIDTH.
- IDLE with start=1, opcode=div and rb==0: in the next cycle set LO=all ones, HI=ra, div_by_zero=1 and pulse done. Latency is 1 and busy never rises.
- MUL/DIV: perform one iteration per cycle and decrement count. When count reaches 1, go to FIN.
- FIN: apply sign fix-up, write rc, pulse done, clear busy and return to IDLE.
- Iterative latency: with start at cycle N, done is high at cycle N+WIDTH+1.
- start while busy=1 is ignored. Operands and opcode may change freely after acceptance.
- done and a new accepted start may occur in the same cycle only from IDLE. A start in the FIN cycle is ignored.
- Single-cycle ops (HI=0 unless stated):
  - add/addi/ldw/ldwi/stw: LO = ra+rb (mod 2^W).
  - sub: LO = ra-rb.
  - and/andi: LO = ra & rb.
  - or/ori: LO = ra | rb.
  - neg: LO = -rb.
  - not: LO = ~rb.
  - shr: logical right shift.
  - shl: left shift.
  - ror/rol: rotate by rb[SHW-1:0]; an amount of 0 passes ra through.
- Multiply: signed W x W -> 2W result, with the true product in {HI, LO}. There is no inversion or truncation.
- Divide: signed. The core runs on magnitudes.
  - The quotient is negated iff the operand signs differ.
  - The remainder takes the sign of the dividend (truncating division).
  - MIN / -1 gives LO=MIN and HI=0, with no flag.
- nop, halt and unknown opcodes: rc=0 and done pulses after 1 cycle.
- rc holds its value between done pulses.
- div_by_zero clears on the next accepted start.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams: ldw=00000, ldwi=00001, stw=00010, add=00011, sub=00100, shr=00101, shl=00110, ror=00111, rol=01000, and=01001, or=01010, addi=01011, andi=01100, ori=01101, mul=01110, div=01111, neg=10000, not=10001, nop=11001, halt=11010.
  - the state encoding IDLE/MUL/DIV/FIN.
- One natural sub-module is iter_divider (WIDTH-parametrised restoring core on unsigned magnitudes, with a load/step interface).
- Booth multiply and the FSM stay inline in seq_alu.

Test Plan:
- WIDTH=32, add ra=7, rb=5 with start at N -> at N+1: done=1, rc=0x0000_0000_0000_000C, busy stays 0.
- mul ra=-3, rb=7 with start at N -> busy over N+1..N+32; at N+33: done=1, rc=0xFFFFFFFF_FFFFFFEB.
- div ra=-17, rb=5 -> at N+33: LO=0xFFFFFFFD (-3), HI=0xFFFFFFFE (-2), div_by_zero=0.
- div ra=9, rb=0 -> at N+1: LO=0xFFFFFFFF, HI=9, div_by_zero=1, busy never rises.
- mul in flight, pulse start(add) at N+5, then clear at N+10 -> add is ignored. After the clear cycle rc=0, busy=0, and no done occurs at N+33.
- rol ra=0x80000001, rb=33 (amount 1) -> LO=0x00000003. WIDTH=8 regression: mul -128 x -128 -> rc=0x4000 at N+9.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU.
// Holds the 5-bit opcode encodings and the controller state encoding.
package alu_pkg;

  localparam logic [4:0] OP_LDW  = 5'b00000;
  localparam logic [4:0] OP_LDWI = 5'b00001;
  localparam logic [4:0] OP_STW  = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_ADDI = 5'b01011;
  localparam logic [4:0] OP_ANDI = 5'b01100;
  localparam logic [4:0] OP_ORI  = 5'b01101;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_NEG  = 5'b10000;
  localparam logic [4:0] OP_NOT  = 5'b10001;
  localparam logic [4:0] OP_NOP  = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

endpackage

// File: rtl/iter_divider.sv
// Restoring divider core on unsigned magnitudes, one quotient bit per step.
// Ports:
//   clk, clear          clock, synchronous active-high reset
//   load                capture dividend/divisor and zero the partial remainder
//   step                perform one restoring iteration
//   dividend, divisor   unsigned magnitudes
//   quo_next, rem_next  quotient/remainder as they will be after the current
//                       step; after WIDTH steps these are the final values
module iter_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quo_next,
  output logic [WIDTH-1:0] rem_next
);

  // quo starts as the dividend; its bits shift out into rem while the
  // quotient bits shift in from the bottom.
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvsr;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;

  always_comb begin
    rem_sh   = {rem, quo[WIDTH-1]};
    diff     = rem_sh - {1'b0, dvsr};
    quo_next = {quo[WIDTH-2:0], ~diff[WIDTH]};
    // Partial remainder stays below the divisor, so W bits always suffice.
    rem_next = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      quo  <= '0;
      rem  <= '0;
      dvsr <= '0;
    end else if (load) begin
      quo  <= dividend;
      rem  <= '0;
      dvsr <= divisor;
    end else if (step) begin
      quo <= quo_next;
      rem <= rem_next;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle ops with a registered result, radix-2 Booth
// multiply and signed restoring divide run iteratively over WIDTH cycles.
// Ports:
//   clk, clear    clock, synchronous active-high reset
//   start         request, sampled only while idle
//   opcode        operation (alu_pkg encodings)
//   ra, rb        operands; shift/rotate amount is rb[SHW-1:0]
//   rc            result {HI, LO}, held between done pulses
//   busy          iterative op in flight
//   done          one-cycle pulse when rc is written
//   div_by_zero   sticky until the next accepted start
//
// state   | meaning
// ST_IDLE | accepts start; single-cycle ops complete from here
// ST_MUL  | one Booth step per cycle, count down from WIDTH
// ST_DIV  | one restoring step per cycle, count down from WIDTH
// ST_FIN  | result written, done high; start ignored
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               start,
  input  logic [4:0]         opcode,
  input  logic [WIDTH-1:0]   ra,
  input  logic [WIDTH-1:0]   rb,
  output logic [2*WIDTH-1:0] rc,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t             state, state_nxt;
  logic [CW-1:0]      count;
  logic               accept, is_mul, is_div, rb_zero, last_step;
  logic [SHW-1:0]     amt;
  logic [WIDTH-1:0]   lo_single, hi_single;
  logic [WIDTH:0]     mcand, booth_hi;
  logic [2*WIDTH+1:0] prod, prod_step;
  logic [WIDTH-1:0]   ra_mag, rb_mag, quo_next, rem_next, quo_fix, rem_fix;
  logic               neg_q, neg_r;

  assign accept    = start && (state == ST_IDLE);
  assign is_mul    = (opcode == OP_MUL);
  assign is_div    = (opcode == OP_DIV);
  assign rb_zero   = (rb == '0);
  assign amt       = rb[SHW-1:0];
  assign last_step = (count == CW'(1));
  assign busy      = (state == ST_MUL) || (state == ST_DIV);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept && is_mul)                 state_nxt = ST_MUL;
        else if (accept && is_div && !rb_zero) state_nxt = ST_DIV;
      end
      ST_MUL, ST_DIV: if (last_step) state_nxt = ST_FIN;
      ST_FIN:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Single-cycle results; the DIV arm is only used for a zero divisor.
  always_comb begin
    lo_single = '0;
    hi_single = '0;
    case (opcode)
      OP_LDW, OP_LDWI, OP_STW, OP_ADD, OP_ADDI: lo_single = ra + rb;
      OP_SUB:          lo_single = ra - rb;
      OP_AND, OP_ANDI: lo_single = ra & rb;
      OP_OR, OP_ORI:   lo_single = ra | rb;
      OP_NEG:          lo_single = -rb;
      OP_NOT:          lo_single = ~rb;
      OP_SHR:          lo_single = ra >> amt;
      OP_SHL:          lo_single = ra << amt;
      // A zero amount makes the complementary shift WIDTH, which yields 0.
      OP_ROR:          lo_single = (ra >> amt) | (ra << (WIDTH - int'(amt)));
      OP_ROL:          lo_single = (ra << amt) | (ra >> (WIDTH - int'(amt)));
      OP_DIV: begin
        lo_single = '1;
        hi_single = ra;
      end
      default: ;
    endcase
  end

  // Booth step: accumulator carries one guard bit so adding/subtracting the
  // most negative multiplicand cannot overflow, then arithmetic shift right.
  always_comb begin
    booth_hi = prod[2*WIDTH+1:WIDTH+1];
    case (prod[1:0])
      2'b01:   booth_hi = booth_hi + mcand;
      2'b10:   booth_hi = booth_hi - mcand;
      default: ;
    endcase
    prod_step = {booth_hi[WIDTH], booth_hi, prod[WIDTH:1]};
  end

  assign ra_mag  = ra[WIDTH-1] ? -ra : ra;
  assign rb_mag  = rb[WIDTH-1] ? -rb : rb;
  assign quo_fix = neg_q ? -quo_next : quo_next;
  assign rem_fix = neg_r ? -rem_next : rem_next;

  iter_divider #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .clear    (clear),
    .load     (accept && is_div && !rb_zero),
    .step     (state == ST_DIV),
    .dividend (ra_mag),
    .divisor  (rb_mag),
    .quo_next (quo_next),
    .rem_next (rem_next)
  );

  always_ff @(posedge clk) begin
    if (clear) begin
      rc          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      count       <= '0;
      prod        <= '0;
      mcand       <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            div_by_zero <= 1'b0;
            count       <= CW'(WIDTH);
            if (is_mul) begin
              prod  <= {{(WIDTH+1){1'b0}}, rb, 1'b0};
              mcand <= {ra[WIDTH-1], ra};
            end else if (is_div && !rb_zero) begin
              neg_q <= ra[WIDTH-1] ^ rb[WIDTH-1];
              neg_r <= ra[WIDTH-1];
            end else begin
              rc   <= {hi_single, lo_single};
              done <= 1'b1;
              if (is_div) div_by_zero <= 1'b1;
            end
          end
        end
        ST_MUL: begin
          prod  <= prod_step;
          count <= count - CW'(1);
          if (last_step) begin
            rc   <= prod_step[2*WIDTH:1];
            done <= 1'b1;
          end
        end
        ST_DIV: begin
          count <= count - CW'(1);
          if (last_step) begin
            rc   <= {rem_fix, quo_fix};
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;
  import alu_pkg::*;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          clear = 1'b1;
  logic          start = 1'b0;
  logic [4:0]    opcode = '0;
  logic [W-1:0]  ra = '0, rb = '0;
  logic [2*W-1:0] rc;
  logic          busy, done, div_by_zero;

  logic          start8 = 1'b0;
  logic [4:0]    op8 = '0;
  logic [7:0]    ra8 = '0, rb8 = '0;
  logic [15:0]   rc8;
  logic          busy8, done8, dbz8;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .clear(clear), .start(start), .opcode(opcode), .ra(ra), .rb(rb),
    .rc(rc), .busy(busy), .done(done), .div_by_zero(div_by_zero)
  );

  seq_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .clear(clear), .start(start8), .opcode(op8), .ra(ra8), .rb(rb8),
    .rc(rc8), .busy(busy8), .done(done8), .div_by_zero(dbz8)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference results from plain signed arithmetic.
  function automatic logic [63:0] model_rc(input logic [4:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    longint sa, sb, q, r, p;
    logic [31:0] lo, hi;
    int n;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    n  = int'(b[4:0]);
    lo = '0;
    hi = '0;
    case (op)
      OP_LDW, OP_LDWI, OP_STW, OP_ADD, OP_ADDI: lo = a + b;
      OP_SUB:          lo = a - b;
      OP_AND, OP_ANDI: lo = a & b;
      OP_OR, OP_ORI:   lo = a | b;
      OP_NEG:          lo = 32'(0 - b);
      OP_NOT:          lo = ~b;
      OP_SHR:          lo = a >> n;
      OP_SHL:          lo = a << n;
      OP_ROR: begin
        lo = a;
        for (int k = 0; k < n; k++) lo = {lo[0], lo[31:1]};
      end
      OP_ROL: begin
        lo = a;
        for (int k = 0; k < n; k++) lo = {lo[30:0], lo[31]};
      end
      OP_MUL: begin
        p = sa * sb;
        {hi, lo} = p;
      end
      OP_DIV: begin
        if (b == 0) begin
          hi = a;
          lo = '1;
        end else begin
          q  = sa / sb;
          r  = sa % sb;
          lo = q[31:0];
          hi = r[31:0];
        end
      end
      default: ;
    endcase
    return {hi, lo};
  endfunction

  // Timeline model: cycle index, acceptance window and pending completion.
  int          cyc = 0;
  int          done_cyc = -1, busy_from = 0, busy_to = -1, idle_from = 0;
  logic [63:0] pend_rc = '0, exp_rc = '0;
  logic        exp_dbz = 1'b0;
  bit          chk_en = 1'b0;

  always @(posedge clk) begin
    if (clear) begin
      chk_en = 1'b1;
      exp_rc = '0;
      exp_dbz = 1'b0;
      done_cyc = -1;
      busy_from = 0;
      busy_to = -1;
      idle_from = 0;
    end else if (start && cyc >= idle_from) begin
      pend_rc = model_rc(opcode, ra, rb);
      exp_dbz = (opcode == OP_DIV) && (rb == 0);
      if (opcode == OP_MUL || (opcode == OP_DIV && rb != 0)) begin
        busy_from = cyc + 1;
        busy_to   = cyc + W;
        done_cyc  = cyc + W + 1;
        idle_from = cyc + W + 2;
      end else begin
        done_cyc = cyc + 1;
      end
    end
    cyc++;
    if (cyc == done_cyc) exp_rc = pend_rc;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("done", done, cyc == done_cyc);
      check("busy", busy, (cyc >= busy_from) && (cyc <= busy_to));
      check("div_by_zero", div_by_zero, exp_dbz);
      check("rc", rc, exp_rc);
    end
  end

  task automatic run_op(input string nm, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat, input logic [63:0] exp_rcv,
                        input logic exp_dz, input logic exp_bseen);
    int t0, lat;
    logic bseen;
    logic [63:0] got;
    logic gdz;
    @(negedge clk);
    start = 1'b1; opcode = op; ra = a; rb = b;
    t0 = cyc; lat = -1; bseen = 1'b0; got = '0; gdz = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      start = 1'b0; opcode = 5'($urandom); ra = $urandom; rb = $urandom;
      bseen = bseen | busy;
      if (done) begin
        lat = cyc - t0;
        got = rc;
        gdz = div_by_zero;
        break;
      end
    end
    check({nm, "_latency"}, lat, exp_lat);
    check({nm, "_rc"}, got, exp_rcv);
    check({nm, "_dbz"}, gdz, exp_dz);
    check({nm, "_busy_seen"}, bseen, exp_bseen);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  logic [4:0] ops [0:23];

  initial begin
    int t0, ndone, lat8;
    ops = '{OP_LDW, OP_LDWI, OP_STW, OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR,
            OP_ROL, OP_AND, OP_OR, OP_ADDI, OP_ANDI, OP_ORI, OP_MUL, OP_DIV,
            OP_NEG, OP_NOT, OP_NOP, OP_HALT, 5'b10010, 5'b11111, OP_MUL, OP_DIV};

    repeat (3) @(negedge clk);
    clear = 1'b0;
    check("rst_rc", rc, 64'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_dbz", div_by_zero, 1'b0);

    run_op("add", OP_ADD, 32'd7, 32'd5, 1, 64'h0000_0000_0000_000C, 1'b0, 1'b0);
    run_op("mul", OP_MUL, -32'sd3, 32'd7, 33, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0, 1'b1);
    run_op("div", OP_DIV, -32'sd17, 32'd5, 33, 64'hFFFF_FFFE_FFFF_FFFD, 1'b0, 1'b1);
    run_op("div0", OP_DIV, 32'd9, 32'd0, 1, 64'h0000_0009_FFFF_FFFF, 1'b1, 1'b0);
    run_op("divmin", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, 64'h0000_0000_8000_0000, 1'b0, 1'b1);
    run_op("ror0", OP_ROR, 32'h1234_5678, 32'd32, 1, 64'h0000_0000_1234_5678, 1'b0, 1'b0);
    run_op("nop", OP_NOP, 32'd3, 32'd4, 1, 64'h0, 1'b0, 1'b0);
    run_op("rol", OP_ROL, 32'h8000_0001, 32'd33, 1, 64'h0000_0000_0000_0003, 1'b0, 1'b0);

    // Clear aborts an in-flight multiply; a start while busy is ignored.
    @(negedge clk);
    start = 1'b1; opcode = OP_MUL; ra = -32'sd3; rb = 32'd7; t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    while (cyc < t0 + 5) @(negedge clk);
    check("clr_busy_mid", busy, 1'b1);
    start = 1'b1; opcode = OP_ADD; ra = 32'd1; rb = 32'd2;
    @(negedge clk);
    start = 1'b0;
    while (cyc < t0 + 10) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clr_rc", rc, 64'h0);
    check("clr_busy", busy, 1'b0);
    ndone = 0;
    while (cyc < t0 + 40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("clr_no_done", ndone, 0);

    // Narrow instance: most negative squared.
    @(negedge clk);
    start8 = 1'b1; op8 = OP_MUL; ra8 = 8'h80; rb8 = 8'h80; t0 = cyc; lat8 = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      start8 = 1'b0;
      if (done8) begin
        lat8 = cyc - t0;
        break;
      end
    end
    check("w8_mul_latency", lat8, 9);
    check("w8_mul_rc", rc8, 16'h4000);

    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 29) == 0) begin
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
      end
      start = 1'b1;
      opcode = ops[$urandom_range(0, 23)];
      ra = rand_operand();
      rb = rand_operand();
      if (opcode == OP_DIV && $urandom_range(0, 4) == 0) rb = '0;
      @(negedge clk);
      start = 1'b0; opcode = 5'($urandom); ra = $urandom; rb = $urandom;
      repeat ($urandom_range(0, 36)) @(negedge clk);
    end

    repeat (40) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
